// File: rtl/conv_encoder_k3.sv
// conv_encoder_k3: rate-1/2, K=3 convolutional encoder (generators 5,7 octal), 4-bit blocks in, 8-bit codewords out.
// Ports:
//   clk        rising-edge clock
//   start      synchronous active-low reset
//   in_valid   / in_ready   block input handshake, data_in[3] encoded first
//   out_valid  / out_ready  codeword output handshake, symbol k at data_out[2k+1:2k]
//   flush      clears the shift register while idle
//   busy       high while encoding or holding a codeword
module conv_encoder_k3 #(
    parameter bit CARRY_STATE = 1'b0
) (
    input  logic       clk,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] data_in,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] data_out,
    input  logic       flush,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, ENCODE, DONE} state_t;
    state_t     state_q;
    logic [1:0] sr_q, sr_d, cnt_q, sym;
    logic [3:0] hold_q;
    logic [7:0] data_q;
    logic       out_valid_q, u;
    // MSB of the block goes out first
    assign u         = hold_q[2'd3 - cnt_q];
    assign sym       = {u ^ sr_q[1], u ^ sr_q[0] ^ sr_q[1]};
    assign sr_d      = {sr_q[0], u};
    // gated by start so in_ready is low for the whole reset period
    assign in_ready  = start && state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign out_valid = out_valid_q;
    assign data_out  = data_q;
    always_ff @(posedge clk) begin
        if (!start) begin
            state_q     <= IDLE;
            sr_q        <= 2'b00;
            cnt_q       <= 2'd0;
            hold_q      <= 4'd0;
            data_q      <= 8'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // flush wins over carry: a block accepted together with flush starts from 0
                    if (flush || (in_valid && !CARRY_STATE)) sr_q <= 2'b00;
                    if (in_valid) begin
                        hold_q  <= data_in;
                        cnt_q   <= 2'd0;
                        state_q <= ENCODE;
                    end
                end
                ENCODE: begin
                    data_q[{cnt_q, 1'b0} +: 2] <= sym;
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_conv_encoder_k3.sv
// tb_conv_encoder_k3: directed bench for conv_encoder_k3, block-reset and carry-state instances driven in lockstep.
module tb_conv_encoder_k3;
    logic       clk = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b1, flush = 1'b0;
    logic [3:0] data_in = 4'd0;
    logic       in_ready0, out_valid0, busy0, in_ready1, out_valid1, busy1;
    logic [7:0] dout0, dout1, c0, c1;
    int         passed = 0, total = 0, lat;

    conv_encoder_k3 #(.CARRY_STATE(1'b0)) dut0 (
        .clk(clk), .start(start), .in_valid(in_valid), .in_ready(in_ready0), .data_in(data_in),
        .out_valid(out_valid0), .out_ready(out_ready), .data_out(dout0), .flush(flush), .busy(busy0));
    conv_encoder_k3 #(.CARRY_STATE(1'b1)) dut1 (
        .clk(clk), .start(start), .in_valid(in_valid), .in_ready(in_ready1), .data_in(data_in),
        .out_valid(out_valid1), .out_ready(out_ready), .data_out(dout1), .flush(flush), .busy(busy1));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one block and waits for out_valid; lat counts edges from acceptance to out_valid.
    task automatic send(input logic [3:0] d, input logic fl);
        int n = 0;
        while (!in_ready0 && n < 20) begin tick(); n++; end
        data_in  = d;
        in_valid = 1'b1;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        lat = 0;
        while (!out_valid0 && lat < 20) begin tick(); lat++; end
        c0 = dout0;
        c1 = dout1;
    endtask

    // Reference encoder in generator form: taps over {u, s0, s1}.
    function automatic logic [7:0] enc(input logic [3:0] d);
        logic [2:0] w;
        logic [1:0] r = 2'b00;
        logic [7:0] c = 8'd0;
        for (int i = 0; i < 4; i++) begin
            w = {d[3 - i], r[0], r[1]};
            c[2 * i + 1] = ^(w & 3'b101);
            c[2 * i]     = ^(w & 3'b111);
            r = {r[0], d[3 - i]};
        end
        return c;
    endfunction

    initial begin
        tick();
        tick();
        check("rst_in_ready", in_ready0, 1'b0);
        check("rst_out_valid", out_valid0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_data_out", dout0, 8'h00);
        start = 1'b1;
        #1;
        check("rel_in_ready", in_ready0, 1'b1);

        send(4'b1011, 1'b0);
        check("basic_latency", lat, 4);
        check("basic_busy", busy0, 1'b1);
        check("basic_cw0", c0, 8'h87);
        check("basic_cw1", c1, 8'h87);
        tick();
        check("basic_hs_out_valid", out_valid0, 1'b0);
        check("basic_hs_in_ready", in_ready0, 1'b1);

        send(4'b0000, 1'b0);
        check("carry_off_0000", c0, 8'h00);
        check("carry_on_0000", c1, 8'h0E);
        tick();

        send(4'b1011, 1'b0);
        check("carry_on_1011", c1, 8'h87);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        send(4'b0000, 1'b0);
        check("flush_idle_0000", c1, 8'h00);
        tick();
        send(4'b1011, 1'b0);
        tick();
        send(4'b0000, 1'b1);
        check("flush_accept_0000", c1, 8'h00);
        tick();

        send(4'b1000, 1'b0);
        check("vec_1000", c0, 8'h37);
        tick();
        send(4'b1111, 1'b0);
        check("vec_1111", c0, 8'h5B);
        tick();
        for (int v = 0; v < 16; v++) begin
            send(4'(v), 1'b0);
            check($sformatf("sweep_%0d", v), c0, enc(4'(v)));
            tick();
        end

        out_ready = 1'b0;
        send(4'b0110, 1'b0);
        check("bp_latency", lat, 4);
        check("bp_cw", c0, 8'hAC);
        for (int i = 0; i < 10; i++) begin
            data_in  = 4'b1111;
            in_valid = i[0];
            tick();
            check($sformatf("bp_hold_%0d", i), dout0, 8'hAC);
            check($sformatf("bp_in_ready_%0d", i), in_ready0, 1'b0);
            check($sformatf("bp_out_valid_%0d", i), out_valid0, 1'b1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_release_out_valid", out_valid0, 1'b0);
        check("bp_release_busy", busy0, 1'b0);
        check("bp_release_keep", dout0, 8'hAC);
        send(4'b1011, 1'b0);
        check("bp_after_cw", c0, 8'h87);
        tick();

        data_in  = 4'b1111;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("mid_busy_before", busy0, 1'b1);
        start = 1'b0;
        tick();
        check("mid_out_valid", out_valid0, 1'b0);
        check("mid_data_out", dout0, 8'h00);
        check("mid_busy", busy0, 1'b0);
        check("mid_busy1", busy1, 1'b0);
        check("mid_in_ready", in_ready0, 1'b0);
        start = 1'b1;
        tick();
        send(4'b1011, 1'b0);
        check("mid_after_lat", lat, 4);
        check("mid_after_cw0", c0, 8'h87);
        check("mid_after_cw1", c1, 8'h87);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
